// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter
// Serialises camera write bursts, VGA read bursts and auto-refresh onto the
// SDRAM command engine, one command at a time, over valid/ready/done.
// Ping-pong frame buffers: the camera fills wr_buf while VGA reads rd_buf,
// which is the most recently completed camera frame.
module sdram_frame_arbiter #(
   parameter int BURST_LEN      = 256,
   parameter int FRAME_WORDS    = 307200,
   parameter int ADDR_W         = 24,
   parameter int REFRESH_CYCLES = 1280,
   parameter int CNT_W          = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  cam_count,
   input  logic [CNT_W-1:0]  vga_space,
   input  logic              cam_frame_start,
   input  logic              vga_frame_start,
   output logic              cmd_valid,
   output logic [1:0]        cmd_op,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_ready,
   input  logic              cmd_done,
   output logic [2:0]        ref_debt,
   output logic              rd_frame_valid
);

   localparam int OFF_W = ADDR_W - 1;
   localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   localparam logic [OFF_W-1:0] BURST_OFF = OFF_W'(BURST_LEN);
   localparam logic [OFF_W-1:0] FRAME_OFF = OFF_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(REFRESH_CYCLES - 1);

   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_REF = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_next_s;

   logic               cmd_valid_r;
   logic [1:0]         cmd_op_r;
   logic [ADDR_W-1:0]  cmd_addr_r;
   logic               cmd_valid_next_s;
   logic [1:0]         cmd_op_next_s;
   logic [ADDR_W-1:0]  cmd_addr_next_s;

   logic               wr_buf_r;
   logic               rd_buf_r;
   logic               done_buf_r;
   logic [OFF_W-1:0]   wr_off_r;
   logic [OFF_W-1:0]   rd_off_r;
   logic [TMR_W-1:0]   tmr_r;
   logic [2:0]         ref_debt_r;
   logic               rd_frame_valid_r;
   logic               last_wr_r;     // 1: last granted burst was a write
   logic               pend_ok_r;     // pending burst still belongs to the current frame

   logic               ref_elig_s;
   logic               wr_elig_s;
   logic               rd_elig_s;
   logic               grant_wr_s;
   logic               grant_rd_s;
   logic               issue_s;
   logic               accept_s;
   logic               acc_wr_s;
   logic               acc_rd_s;
   logic               acc_ref_s;
   logic               tmr_wrap_s;

   assign cmd_valid      = cmd_valid_r;
   assign cmd_op         = cmd_op_r;
   assign cmd_addr       = cmd_addr_r;
   assign ref_debt       = ref_debt_r;
   assign rd_frame_valid = rd_frame_valid_r;

   // Eligibility, priority (refresh first, then write/read round-robin) and handshake decode
   always_comb begin
      ref_elig_s = (ref_debt_r != 3'd0);
      wr_elig_s  = (cam_count >= BURST_CNT) && (wr_off_r < FRAME_OFF);
      rd_elig_s  = rd_frame_valid_r && (vga_space >= BURST_CNT) && (rd_off_r < FRAME_OFF);
      grant_wr_s = !ref_elig_s && wr_elig_s && (!rd_elig_s || !last_wr_r);
      grant_rd_s = !ref_elig_s && rd_elig_s && !grant_wr_s;
      issue_s    = (state_r == ST_IDLE) && (ref_elig_s || wr_elig_s || rd_elig_s);
      accept_s   = (state_r == ST_ISSUE) && cmd_ready;
      acc_wr_s   = accept_s && (cmd_op_r == OP_WR);
      acc_rd_s   = accept_s && (cmd_op_r == OP_RD);
      acc_ref_s  = accept_s && (cmd_op_r == OP_REF);
      tmr_wrap_s = (tmr_r == TMR_LAST);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; a cmd_done outside BUSY has no effect
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (issue_s) state_next_s = ST_ISSUE;
            else         state_next_s = ST_IDLE;
         end
         ST_ISSUE: begin
            if (cmd_ready) state_next_s = ST_BUSY;
            else           state_next_s = ST_ISSUE;
         end
         ST_BUSY: begin
            if (cmd_done) state_next_s = ST_IDLE;
            else          state_next_s = ST_BUSY;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM output logic: next values of the registered command fields
   always_comb begin
      cmd_valid_next_s = cmd_valid_r;
      cmd_op_next_s    = cmd_op_r;
      cmd_addr_next_s  = cmd_addr_r;
      case (state_r)
         ST_IDLE: begin
            if (issue_s) begin
               cmd_valid_next_s = 1'b1;
               if (ref_elig_s) begin
                  cmd_op_next_s   = OP_REF;
                  cmd_addr_next_s = {ADDR_W{1'b0}};
               end else if (grant_wr_s) begin
                  cmd_op_next_s   = OP_WR;
                  cmd_addr_next_s = {wr_buf_r, wr_off_r};
               end else begin
                  cmd_op_next_s   = OP_RD;
                  cmd_addr_next_s = {rd_buf_r, rd_off_r};
               end
            end else begin
               cmd_valid_next_s = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) cmd_valid_next_s = 1'b0;
            else           cmd_valid_next_s = 1'b1;
         end
         ST_BUSY: cmd_valid_next_s = 1'b0;
         default: cmd_valid_next_s = 1'b0;
      endcase
   end

   // Command output registers; op/addr hold steady from issue until accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_valid_r <= 1'b0;
         cmd_op_r    <= 2'b00;
         cmd_addr_r  <= {ADDR_W{1'b0}};
      end else begin
         cmd_valid_r <= cmd_valid_next_s;
         cmd_op_r    <= cmd_op_next_s;
         cmd_addr_r  <= cmd_addr_next_s;
      end
   end

   // Tracks whether a frame start invalidated the pending burst, so its accept does not advance the new frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_ok_r <= 1'b0;
      end else if (issue_s) begin
         if (grant_wr_s)      pend_ok_r <= !cam_frame_start;
         else if (grant_rd_s) pend_ok_r <= !vga_frame_start;
         else                 pend_ok_r <= 1'b1;
      end else if ((state_r == ST_ISSUE) && (cmd_op_r == OP_WR) && cam_frame_start) begin
         pend_ok_r <= 1'b0;
      end else if ((state_r == ST_ISSUE) && (cmd_op_r == OP_RD) && vga_frame_start) begin
         pend_ok_r <= 1'b0;
      end
   end

   // Camera side: write offset, buffer ping-pong and completed-frame hand-off
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_buf_r         <= 1'b0;
         wr_off_r         <= {OFF_W{1'b0}};
         done_buf_r       <= 1'b0;
         rd_frame_valid_r <= 1'b0;
      end else if (cam_frame_start) begin
         if (wr_off_r == FRAME_OFF) begin
            done_buf_r       <= wr_buf_r;
            rd_frame_valid_r <= 1'b1;
         end
         wr_buf_r <= ~wr_buf_r;
         wr_off_r <= {OFF_W{1'b0}};
      end else if (acc_wr_s && pend_ok_r) begin
         wr_off_r <= wr_off_r + BURST_OFF;
      end
   end

   // VGA side: read offset, restarted on the newest completed buffer at each VGA frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_buf_r <= 1'b0;
         rd_off_r <= {OFF_W{1'b0}};
      end else if (vga_frame_start) begin
         rd_buf_r <= done_buf_r;
         rd_off_r <= {OFF_W{1'b0}};
      end else if (acc_rd_s && pend_ok_r) begin
         rd_off_r <= rd_off_r + BURST_OFF;
      end
   end

   // Round-robin memory: which of write/read was accepted last
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_wr_r <= 1'b0;
      end else if (acc_wr_s) begin
         last_wr_r <= 1'b1;
      end else if (acc_rd_s) begin
         last_wr_r <= 1'b0;
      end
   end

   // Free-running refresh interval timer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmr_r <= {TMR_W{1'b0}};
      end else if (tmr_wrap_s) begin
         tmr_r <= {TMR_W{1'b0}};
      end else begin
         tmr_r <= tmr_r + TMR_W'(1);
      end
   end

   // Outstanding refresh count: +1 per interval (saturating at 7), -1 per refresh accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_debt_r <= 3'd0;
      end else if (tmr_wrap_s && !acc_ref_s) begin
         if (ref_debt_r != 3'd7) ref_debt_r <= ref_debt_r + 3'd1;
      end else if (acc_ref_s && !tmr_wrap_s) begin
         ref_debt_r <= ref_debt_r - 3'd1;
      end
   end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Randomised scoreboard bench for sdram_frame_arbiter.
// A transaction-level reference model predicts each command at the moment
// the arbiter should choose it and queues it; a monitor pops and compares
// on every accepted command. Status outputs are compared every cycle.
module tb_sdram_frame_arbiter;

   localparam int BL   = 4;
   localparam int FW   = 16;
   localparam int RC   = 50;
   localparam int AW   = 24;
   localparam int CW   = 10;
   localparam int NCYC = 3000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] cam_count;
   logic [CW-1:0] vga_space;
   logic          cam_frame_start;
   logic          vga_frame_start;
   logic          cmd_valid;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic          cmd_ready;
   logic          cmd_done;
   logic [2:0]    ref_debt;
   logic          rd_frame_valid;

   sdram_frame_arbiter #(
      .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .REFRESH_CYCLES(RC), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cam_count(cam_count), .vga_space(vga_space),
      .cam_frame_start(cam_frame_start), .vga_frame_start(vga_frame_start),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_ready(cmd_ready), .cmd_done(cmd_done),
      .ref_debt(ref_debt), .rd_frame_valid(rd_frame_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] addr;
   } cmd_t;

   cmd_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state (frame-level view of the arbiter)
   int m_wbuf = 0, m_rbuf = 0, m_done = 0, m_woff = 0, m_roff = 0;
   int m_debt = 0, m_tick = 0, m_wep = 0, m_rep = 0, m_cmd_ep = 0, m_cmd_op = 0;
   bit m_frame_ok = 0, m_last_wr = 0, m_offering = 0, m_running = 0;
   bit m_known = 0, m_rst_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [CW-1:0] rand_level();
      if ($urandom_range(3, 0) == 0) return CW'($urandom_range(3, 0));
      else                           return CW'($urandom_range(40, 4));
   endfunction

   // Advance the model by one clock, using the inputs that the coming edge will see
   task automatic model_step();
      int   old_woff, old_done, pick, d;
      bit   wr_ok, rd_ok, acc, fin, wrap;
      cmd_t c;
      if (!rst_n) begin
         m_wbuf = 0; m_rbuf = 0; m_done = 0; m_woff = 0; m_roff = 0;
         m_debt = 0; m_tick = 0; m_wep = 0; m_rep = 0; m_cmd_ep = 0; m_cmd_op = 0;
         m_frame_ok = 0; m_last_wr = 0; m_offering = 0; m_running = 0;
         exp_q.delete();
         m_known = 1; m_rst_seen = 1;
         return;
      end
      m_rst_seen = 0;
      acc      = m_offering && (cmd_ready === 1'b1);
      fin      = m_running && (cmd_done === 1'b1);
      wrap     = (m_tick == RC - 1);
      old_woff = m_woff;
      old_done = m_done;
      pick     = 0;
      if (!m_offering && !m_running) begin
         wr_ok = (int'(cam_count) >= BL) && (m_woff < FW);
         rd_ok = m_frame_ok && (int'(vga_space) >= BL) && (m_roff < FW);
         if (m_debt > 0)            pick = 3;
         else if (wr_ok && rd_ok)   pick = m_last_wr ? 2 : 1;
         else if (wr_ok)            pick = 1;
         else if (rd_ok)            pick = 2;
      end
      // refresh debt: plain arithmetic with a ceiling
      d = m_debt;
      if (wrap) d++;
      if (acc && m_cmd_op == 3) d--;
      if (d > 7) d = 7;
      m_debt = d;
      // accepted bursts advance their frame only if no frame start intervened
      if (acc && m_cmd_op == 1) begin
         if (m_cmd_ep == m_wep) m_woff += BL;
         m_last_wr = 1;
      end
      if (acc && m_cmd_op == 2) begin
         if (m_cmd_ep == m_rep) m_roff += BL;
         m_last_wr = 0;
      end
      if (pick != 0) begin
         c.op = 2'(pick);
         if (pick == 1)      c.addr = AW'(m_wbuf * (1 << (AW - 1)) + m_woff);
         else if (pick == 2) c.addr = AW'(m_rbuf * (1 << (AW - 1)) + m_roff);
         else                c.addr = '0;
         exp_q.push_back(c);
         m_cmd_op = pick;
         m_cmd_ep = (pick == 1) ? m_wep : m_rep;
      end
      if (cam_frame_start) begin
         if (old_woff == FW) begin
            m_done     = m_wbuf;
            m_frame_ok = 1;
         end
         m_wbuf = 1 - m_wbuf;
         m_woff = 0;
         m_wep++;
      end
      if (vga_frame_start) begin
         m_rbuf = old_done;
         m_roff = 0;
         m_rep++;
      end
      if (acc) begin
         m_offering = 0;
         m_running  = 1;
      end else if (fin) begin
         m_running = 0;
      end
      if (pick != 0) m_offering = 1;
      m_tick = (m_tick + 1) % RC;
   endtask

   // Monitor: every accepted command must match the oldest predicted one
   always @(negedge clk) begin
      cmd_t e;
      if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL cmd_accept: got op %0d addr 0x%0h, expected no command at %0t",
                     cmd_op, cmd_addr, $time);
         end else begin
            e = exp_q.pop_front();
            check("cmd op/addr", {6'd0, cmd_op, cmd_addr}, {6'd0, e.op, e.addr});
         end
      end
   end

   int eng_cnt = 0;
   int hold_ready = 0;
   int fs_div;
   bit acc_flag = 0;
   bit mid_rst_done = 0;

   // Stimulus, SDRAM engine emulation and per-cycle status checking
   initial begin
      rst_n = 1'b0; cam_count = '0; vga_space = '0;
      cam_frame_start = 1'b0; vga_frame_start = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         // engine: done 1..5 cycles after accept, spurious done pulses while nothing is in flight
         if (acc_flag) eng_cnt = $urandom_range(5, 1);
         cmd_done = 1'b0;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) cmd_done = 1'b1;
         end else if ($urandom_range(7, 0) == 0) begin
            cmd_done = 1'b1;
         end
         rst_n = (cyc >= 3) ? 1'b1 : 1'b0;
         cam_frame_start = 1'b0;
         vga_frame_start = 1'b0;
         if (cyc < 41) begin
            // first write held in ISSUE while the camera frame restarts
            cam_count       = CW'(4);
            vga_space       = CW'(0);
            cmd_ready       = (cyc >= 16) ? 1'b1 : 1'b0;
            cam_frame_start = (cyc == 10) ? 1'b1 : 1'b0;
         end else begin
            cam_count = rand_level();
            vga_space = rand_level();
            cmd_ready = ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0;
            fs_div    = (cyc > 1000 && cyc <= 1400) ? 8 : 40;
            cam_frame_start = ($urandom_range(fs_div - 1, 0) == 0) ? 1'b1 : 1'b0;
            vga_frame_start = ($urandom_range(fs_div - 1, 0) == 0) ? 1'b1 : 1'b0;
            if (cyc > 600 && cyc <= 1000) cmd_ready = 1'b0;
            if (hold_ready > 0) begin
               hold_ready--;
               cmd_ready = 1'b0;
            end
            if (cyc > 1800 && !mid_rst_done && eng_cnt >= 2) begin
               // reset while a burst is executing; its done arrives afterwards
               rst_n        = 1'b0;
               mid_rst_done = 1'b1;
               hold_ready   = 3;
            end
         end
         @(negedge clk);
         acc_flag = (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1);
         if (m_known) begin
            check("status {valid,debt,frame_ok}",
                  {27'd0, cmd_valid, ref_debt, rd_frame_valid},
                  {27'd0, m_offering, 3'(m_debt), m_frame_ok});
            if (m_rst_seen) check("reset cmd op/addr", {6'd0, cmd_op, cmd_addr}, 32'd0);
         end
         if (cyc == 1000) check("ref_debt saturated", {29'd0, ref_debt}, 32'd7);
         model_step();
      end
      check("final pending queue depth", exp_q.size(), m_offering ? 32'd1 : 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
